tt_dfd_ffs_dispatch: RTL and testbench
======================================

# tt_dfd_ffs_dispatch

Indexed dispatcher that performs the inverse of the find-first-set encoder. It accepts one payload per cycle tagged with a binary destination index, decodes the index to one-hot, and delivers the payload into a one-entry holding register for the selected output lane. Each lane has its own valid/ready handshake. It sits downstream of a priority encoder or any binary-tagged source and fans requests back out to per-requester consumers in the debug fabric.

## Interface
Parameters:
- WIDTH, 8, number of output lanes.
- SIZE, max($clog2(WIDTH),1), width of the destination index.
- DATA_WIDTH, 4, payload width per lane.

Ports:
- clk  input  1  single clock; all state is rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_vld  input  1  input payload valid.
- in_idx  input  SIZE  binary destination lane.
- in_bcast  input  1  deliver the payload to all lanes; in_idx is ignored.
- in_data  input  DATA_WIDTH  payload.
- in_rdy  output  1  input accepted when in_vld & in_rdy.
- out_vld  output  WIDTH  per-lane holding register full.
- out_data  output  WIDTH x DATA_WIDTH  per-lane payload.
- out_rdy  input  WIDTH  per-lane consumer ready.
- err_oob  output  1  one-cycle pulse: an accepted unicast had in_idx >= WIDTH.
- drop_cnt  output  8  saturating count of out-of-range drops.

## Operation
- Per-lane state is lane_vld[i] (drives out_vld[i]) and lane_data[i] (drives out_data[i]).
- Lane i can accept (lane_free[i]) when ~lane_vld[i] | out_rdy[i], which allows a same-cycle drain and refill.
- in_rdy:
  - Broadcast: &lane_free.
  - Unicast with in_idx < WIDTH: lane_free[in_idx].
  - Unicast with in_idx >= WIDTH: 1. The payload is always accepted and dropped.
- Unicast accept, in range: lane_vld[in_idx] <= 1 and lane_data[in_idx] <= in_data. Other lanes are unaffected except for their own drains.
- Broadcast accept: every lane loads in_data and sets lane_vld.
- Out-of-range unicast accept:
  - No lane changes.
  - err_oob pulses high for the next cycle.
  - drop_cnt increments, saturating at 255.
- Lane drain: when out_vld[i] & out_rdy[i] and there is no refill of i in the same cycle, lane_vld[i] <= 0 and lane_data[i] holds its last value.
- in_vld low: nothing is loaded, and in_idx, in_bcast and in_data are don't-care.
- The lanes are independent of each other. No ordering is guaranteed across lanes; order within a lane is FIFO of depth 1.
- Only lanes 0..WIDTH-1 exist. When WIDTH is a power of two, the out-of-range case is unreachable.

## Timing
- Reset (async assert, sync release) clears out_vld, out_data, err_oob and drop_cnt to 0.
- Latency: a payload accepted at edge N is visible on out_vld/out_data after edge N. That is 1 cycle.
- Throughput is 1 payload per cycle to the same lane while out_rdy[lane] is held high.
- Combinational paths:
  - in_rdy depends combinationally on out_rdy, in_idx and in_bcast.
  - out_vld and out_data are registered only.
- The source must hold in_vld, in_idx, in_bcast and in_data stable until accepted. The block does not check this.
- Broadcast that is blocked by any single full, stalled lane keeps in_rdy low and loads no lane. Broadcast is all-or-nothing.
- err_oob is a registered pulse, high exactly one cycle per dropped beat. Back-to-back drops hold it high continuously.
- Reset asserted mid-transfer discards all held payloads immediately. No out_vld glitches after the reset edge.

## Structure
- The shared package tt_dfd_ffs_pkg holds:
  - a helper function for SIZE;
  - the DROP_CNT_W = 8 constant.
- Natural sub-module: tt_dfd_ffs_dispatch_slot, instantiated WIDTH times. It is a one-entry valid/data register with a load/drain handshake.
- The top level holds the decode (binary to one-hot, OR'd with the broadcast mask), the in_rdy mux and the error/drop logic.

## Test plan
- Unicast: WIDTH=8, in_idx=5, data=0xA, all out_rdy=1 -> next cycle out_vld=8'b0010_0000 and out_data[5]=0xA. One cycle later out_vld=0.
- Backpressure:
  - out_rdy[2]=0, send idx=2 data 0x3 then idx=2 data 0x4 -> the second beat sees in_rdy=0 until out_rdy[2]=1.
  - In that cycle lane 2 drains 0x3 and loads 0x4 with no bubble.
- Broadcast: in_bcast=1 with lane 7 full and stalled -> in_rdy=0 and no lane loads. Releasing out_rdy[7] -> all 8 lanes show the payload the next cycle.
- Out of range: WIDTH=6, in_idx=7 -> in_rdy=1, no out_vld change, err_oob high 1 cycle, drop_cnt=1. After 300 drops, drop_cnt=255.
- Independence: idx 0,1,2 in consecutive cycles with out_rdy=0 -> out_vld=3'b111 after 3 cycles. Random out_rdy shows per-lane FIFO order preserved.
- Reset mid-stream: assert reset_n=0 with lanes full -> out_vld=0 and drop_cnt=0 asynchronously. After release, the first accept behaves normally.

Source files
------------

// File: rtl/tt_dfd_ffs_pkg.sv
// Shared constants and helpers for the indexed find-first-set dispatcher.
package tt_dfd_ffs_pkg;

    // Width of the saturating drop counter.
    localparam int DROP_CNT_W = 8;

    // Destination index width; a single lane still needs a one-bit index.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/tt_dfd_ffs_dispatch_slot.sv
// One-entry holding register for a single output lane. Supports drain and
// refill in the same cycle so a lane can sustain one payload per cycle.
module tt_dfd_ffs_dispatch_slot #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rdy_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  free_o
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Load wins over drain; a drained slot keeps its last payload.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign free_o = ~vld_q | rdy_i;
    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/tt_dfd_ffs_dispatch.sv
// Indexed dispatcher: decodes a binary destination index (or broadcast) and
// delivers the payload into the selected lane's one-entry holding slot.
// Out-of-range unicast beats are accepted, dropped, flagged and counted.
module tt_dfd_ffs_dispatch
    import tt_dfd_ffs_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIZE       = idx_width(WIDTH),
    parameter int DATA_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_vld,
    input  logic [SIZE-1:0]                     in_idx,
    input  logic                                in_bcast,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_rdy,
    output logic [WIDTH-1:0]                    out_vld,
    output logic [WIDTH-1:0][DATA_WIDTH-1:0]    out_data,
    input  logic [WIDTH-1:0]                    out_rdy,
    output logic                                err_oob,
    output logic [DROP_CNT_W-1:0]               drop_cnt
);

    logic [WIDTH-1:0]      lane_free;
    logic [WIDTH-1:0]      idx_onehot;
    logic [WIDTH-1:0]      lane_load;
    logic                  idx_in_range;
    logic                  accept;
    logic                  drop;

    logic                  err_oob_q, err_oob_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Binary to one-hot; an index past the last lane decodes to all zeros.
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx_onehot[i] = (in_idx == SIZE'(i));
        end
    end

    assign idx_in_range = |idx_onehot;

    // Broadcast is all-or-nothing; dropped beats never stall the source.
    always_comb begin
        in_rdy = 1'b1;
        if (in_bcast)          in_rdy = &lane_free;
        else if (idx_in_range) in_rdy = |(idx_onehot & lane_free);
    end

    assign accept    = in_vld & in_rdy;
    assign lane_load = accept ? (in_bcast ? '1 : idx_onehot) : '0;
    assign drop      = accept & ~in_bcast & ~idx_in_range;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        tt_dfd_ffs_dispatch_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (lane_load[g]),
            .data_i  (in_data),
            .rdy_i   (out_rdy[g]),
            .vld_o   (out_vld[g]),
            .data_o  (out_data[g]),
            .free_o  (lane_free[g])
        );
    end

    // Error pulse follows each drop; counter saturates at all-ones.
    always_comb begin
        err_oob_d  = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Error/drop state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_oob_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_oob_q  <= err_oob_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_oob  = err_oob_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tt_dfd_ffs_dispatch.sv
// Bench for tt_dfd_ffs_dispatch with six lanes, so indices 6 and 7 are
// out of range. A lane-array model tracks expected state from the rules.
module tb_tt_dfd_ffs_dispatch;

    localparam int W  = 6;
    localparam int SZ = 3;
    localparam int DW = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_vld = 1'b0;
    logic [SZ-1:0]      in_idx = '0;
    logic               in_bcast = 1'b0;
    logic [DW-1:0]      in_data = '0;
    logic               in_rdy;
    logic [W-1:0]       out_vld;
    logic [W-1:0][DW-1:0] out_data;
    logic [W-1:0]       out_rdy = '1;
    logic               err_oob;
    logic [7:0]         drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [W-1:0] m_vld;
    logic [DW-1:0] m_data [W];
    logic m_err;
    int   m_cnt;

    tt_dfd_ffs_dispatch #(.WIDTH(W), .SIZE(SZ), .DATA_WIDTH(DW)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (in_vld),
        .in_idx   (in_idx),
        .in_bcast (in_bcast),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .err_oob  (err_oob),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_vld = '0;
        for (int i = 0; i < W; i++) m_data[i] = '0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // Whether the model would take the currently driven beat.
    function automatic logic model_rdy();
        int k;
        if (in_bcast) begin
            for (int i = 0; i < W; i++)
                if (m_vld[i] && !out_rdy[i]) return 1'b0;
            return 1'b1;
        end
        k = int'(in_idx);
        if (k < W) return !m_vld[k] || out_rdy[k];
        return 1'b1;
    endfunction

    // Advance one rising edge and apply the rules to the model; returns #1 after the edge.
    task automatic step();
        logic acc, bc;
        int k;
        logic [DW-1:0] d;
        logic [W-1:0] rdy;
        acc = in_vld && model_rdy();
        bc  = in_bcast;
        k   = int'(in_idx);
        d   = in_data;
        rdy = out_rdy;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            if (acc && (bc || k == i)) begin
                m_vld[i]  = 1'b1;
                m_data[i] = d;
            end else if (m_vld[i] && rdy[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        m_err = acc && !bc && (k >= W);
        if (m_err && m_cnt < 255) m_cnt++;
        #1;
    endtask

    task automatic drive(input logic v, input int idx, input logic bc, input logic [DW-1:0] d);
        in_vld   = v;
        in_idx   = SZ'(idx);
        in_bcast = bc;
        in_data  = d;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        checks++; if (out_vld !== 6'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", out_vld); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_oob); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", drop_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unicast();
        out_rdy = '1;
        drive(1, 5, 0, 4'hA); #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL uni_rdy got=%b exp=1", in_rdy); end
        step();
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld !== 6'b100000) begin errors++; $display("FAIL uni_vld got=%b exp=100000", out_vld); end
        checks++; if (out_data[5] !== 4'hA) begin errors++; $display("FAIL uni_data got=%h exp=a", out_data[5]); end
        step();
        checks++; if (out_vld !== 6'b0) begin errors++; $display("FAIL uni_drain got=%b exp=0", out_vld); end
        checks++; if (out_data[5] !== 4'hA) begin errors++; $display("FAIL uni_hold got=%h exp=a", out_data[5]); end
    endtask

    task automatic test_backpressure();
        out_rdy = 6'b111011;
        drive(1, 2, 0, 4'h3); step();
        drive(1, 2, 0, 4'h4); #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", in_rdy); end
        step();
        checks++; if (out_vld[2] !== 1'b1 || out_data[2] !== 4'h3) begin
            errors++; $display("FAIL bp_hold got=%b/%h exp=1/3", out_vld[2], out_data[2]); end
        out_rdy = '1; #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_rdy); end
        step();
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld[2] !== 1'b1 || out_data[2] !== 4'h4) begin
            errors++; $display("FAIL bp_refill got=%b/%h exp=1/4", out_vld[2], out_data[2]); end
        step();
    endtask

    task automatic test_broadcast();
        out_rdy = 6'b011111;
        drive(1, 5, 0, 4'h7); step();
        drive(1, 3, 1, 4'h9); #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bc_block got=%b exp=0", in_rdy); end
        step();
        checks++; if (out_vld !== 6'b100000 || out_data[5] !== 4'h7) begin
            errors++; $display("FAIL bc_noload got=%b/%h exp=100000/7", out_vld, out_data[5]); end
        out_rdy = '1; #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bc_release got=%b exp=1", in_rdy); end
        step();
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld !== 6'b111111 || out_data !== {W{4'h9}}) begin
            errors++; $display("FAIL bc_all got=%b/%h exp=111111/999999", out_vld, out_data); end
        step();
    endtask

    task automatic test_oob();
        drive(1, 7, 0, 4'h5); #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL oob_rdy got=%b exp=1", in_rdy); end
        step();
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld !== 6'b0 || err_oob !== 1'b1 || drop_cnt !== 8'd1) begin
            errors++; $display("FAIL oob_first got=%b/%b/%0d exp=0/1/1", out_vld, err_oob, drop_cnt); end
        step();
        checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_pulse got=%b exp=0", err_oob); end
        for (int n = 0; n < 300; n++) begin
            drive(1, 6 + (n % 2), 0, 4'(n));
            step();
        end
        drive(0, 0, 0, 4'h0);
        checks++; if (err_oob !== 1'b1 || drop_cnt !== 8'd255) begin
            errors++; $display("FAIL oob_sat got=%b/%0d exp=1/255", err_oob, drop_cnt); end
        step();
        checks++; if (err_oob !== 1'b0 || drop_cnt !== 8'd255) begin
            errors++; $display("FAIL oob_idle got=%b/%0d exp=0/255", err_oob, drop_cnt); end
    endtask

    task automatic test_independence();
        out_rdy = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 0, 4'(i + 1));
            step();
        end
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld !== 6'b000111) begin errors++; $display("FAIL ind_vld got=%b exp=000111", out_vld); end
        out_rdy = '1; step();
    endtask

    task automatic test_random();
        logic pend = 1'b0;
        logic exp_rdy;
        int bad;
        for (int n = 0; n < 500; n++) begin
            if (!pend) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                      $urandom_range(0, 7) == 0, 4'($urandom));
            end
            out_rdy = 6'($urandom);
            #1;
            exp_rdy = model_rdy();
            checks++; if (in_rdy !== exp_rdy) begin
                errors++; $display("FAIL rnd_rdy n=%0d got=%b exp=%b", n, in_rdy, exp_rdy); end
            pend = in_vld && !exp_rdy;
            step();
            bad = 0;
            for (int i = 0; i < W; i++) if (out_data[i] !== m_data[i]) bad++;
            checks++; if (out_vld !== m_vld || bad != 0 || err_oob !== m_err || drop_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_state n=%0d vld=%b exp=%b databad=%0d err=%b exp=%b cnt=%0d exp=%0d",
                         n, out_vld, m_vld, bad, err_oob, m_err, drop_cnt, m_cnt);
            end
        end
        drive(0, 0, 0, 4'h0);
        out_rdy = '1; step();
    endtask

    task automatic test_reset_mid();
        out_rdy = '0;
        drive(1, 0, 1, 4'hC); step();
        drive(1, 6, 0, 4'h1); step();
        drive(0, 0, 0, 4'h0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_vld !== 6'b0 || drop_cnt !== 8'd0 || err_oob !== 1'b0) begin
            errors++; $display("FAIL rst_mid got=%b/%0d/%b exp=0/0/0", out_vld, drop_cnt, err_oob); end
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = '1;
        drive(1, 1, 0, 4'h5); #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b exp=1", in_rdy); end
        step();
        drive(0, 0, 0, 4'h0);
        checks++; if (out_vld !== 6'b000010 || out_data[1] !== 4'h5) begin
            errors++; $display("FAIL rst_first got=%b/%h exp=000010/5", out_vld, out_data[1]); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_oob();
        test_independence();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
